// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency main memory between
// instruction fetch and the memory pipeline stage. Data accesses win ties; a
// requester finishing an access sits out the arbitration in its own valid
// cycle, which also guarantees fetch a slot between back-to-back data accesses.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int MEM_LATENCY  = 2    // 1..15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDRESS_BITS-1:0] i_addr,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDRESS_BITS-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_valid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_valid,
    output logic                    stall_fetch,
    output logic                    stall_mem,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [3:0]            CNT_LOAD = 4'(MEM_LATENCY - 1);
    localparam logic [DATA_WIDTH-1:0] NOP_INSN = DATA_WIDTH'(32'h0000_0013);

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic                    store_q, store_d;      // current D access is a store
    logic [3:0]              cnt_q, cnt_d;          // cycles left until the data cycle
    logic [ADDRESS_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                    i_valid_q, i_valid_d;
    logic                    d_valid_q, d_valid_d;

    logic d_elig;
    logic i_elig;

    // A requester finishing in RESP still has its request line high; exclude it.
    assign d_elig = (d_read || d_write) && !(state_q == S_RESP && owner_q == OWN_D);
    assign i_elig = i_req && !(state_q == S_RESP && owner_q == OWN_I);

    // Next-state and datapath-load logic for the access sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        owner_d     = owner_q;
        store_d     = store_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;

        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (d_elig) begin
                    owner_d     = OWN_D;
                    store_d     = d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_read_d  = d_read;
                    mem_write_d = d_write;
                    state_d     = S_ISSUE;
                end else if (i_elig) begin
                    owner_d     = OWN_I;
                    store_d     = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                    mem_read_d  = 1'b1;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Data cycle: mem_rdata is valid now.
                    if (owner_q == OWN_I) begin
                        i_rdata_d = mem_rdata;
                        i_valid_d = 1'b1;
                    end else begin
                        if (!store_q) d_rdata_d = mem_rdata;
                        d_valid_d = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; synchronous reset aborts any access in flight.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_I;
            store_q     <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_rdata_q   <= NOP_INSN;
            d_rdata_q   <= '0;
            i_valid_q   <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_valid_q   <= i_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_valid     = i_valid_q;
    assign d_valid     = d_valid_q;
    assign stall_fetch = i_req && !i_valid_q;
    assign stall_mem   = (d_read || d_write) && !d_valid_q;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: per-cycle vector table for single fetch,
// simultaneous requests and a store (MEM_LATENCY=2), then hand-written
// sequences for back-to-back arbitration, reset mid-access and a
// MEM_LATENCY=1 instance.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 20;
    localparam logic [31:0] G   = 32'hBAD0_BAD0;  // mem_rdata outside data cycles
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_rdata1;

    logic [AW-1:0] mem_addr, mem_addr1;
    logic [DW-1:0] mem_wdata, mem_wdata1;
    logic          mem_read, mem_read1;
    logic          mem_write, mem_write1;
    logic [DW-1:0] i_rdata, i_rdata1;
    logic          i_valid, i_valid1;
    logic [DW-1:0] d_rdata, d_rdata1;
    logic          d_valid, d_valid1;
    logic          stall_fetch, stall_fetch1;
    logic          stall_mem, stall_mem1;
    logic          busy, busy1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MEM_LATENCY(2)) u_dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .i_rdata(i_rdata), .i_valid(i_valid), .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem), .busy(busy)
    );

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MEM_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_rdata(mem_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_read(mem_read1), .mem_write(mem_write1),
        .i_rdata(i_rdata1), .i_valid(i_valid1), .d_rdata(d_rdata1), .d_valid(d_valid1),
        .stall_fetch(stall_fetch1), .stall_mem(stall_mem1), .busy(busy1)
    );

    typedef struct {
        logic          i_req;
        logic [AW-1:0] i_addr;
        logic          d_read;
        logic          d_write;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic [DW-1:0] mem_rdata;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_iv;
        logic          e_dv;
        logic          e_sf;
        logic          e_sm;
        logic          e_busy;
        logic [DW-1:0] e_ird;
        logic [DW-1:0] e_drd;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive all inputs idle, hold reset for two edges, leave time at #1 after an edge.
    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = G; mem_rdata1 = G;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Single fetch (A0..A5)
        v = '{1'b1, 20'h00010, 1'b0, 1'b0, 20'h0, 32'h0, G,          1'b0, 1'b0, 20'h00000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOP, 32'h0}; tbl.push_back(v);
        v = '{1'b1, 20'h00010, 1'b0, 1'b0, 20'h0, 32'h0, G,          1'b1, 1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, NOP, 32'h0}; tbl.push_back(v);
        v = '{1'b1, 20'h00010, 1'b0, 1'b0, 20'h0, 32'h0, G,          1'b0, 1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, NOP, 32'h0}; tbl.push_back(v);
        v = '{1'b1, 20'h00010, 1'b0, 1'b0, 20'h0, 32'h0, 32'h00500093, 1'b0, 1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, NOP, 32'h0}; tbl.push_back(v);
        v = '{1'b1, 20'h00010, 1'b0, 1'b0, 20'h0, 32'h0, G,          1'b0, 1'b0, 20'h00010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h0}; tbl.push_back(v);
        v = '{1'b0, 20'h00010, 1'b0, 1'b0, 20'h0, 32'h0, G,          1'b0, 1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h0}; tbl.push_back(v);
        // Simultaneous fetch and load (B0..B9)
        v = '{1'b1, 20'h00044, 1'b1, 1'b0, 20'h00030, 32'h0, G,          1'b0, 1'b0, 20'h00010, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00500093, 32'h0}; tbl.push_back(v);
        v = '{1'b1, 20'h00044, 1'b1, 1'b0, 20'h00030, 32'h0, G,          1'b1, 1'b0, 20'h00030, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00500093, 32'h0}; tbl.push_back(v);
        v = '{1'b1, 20'h00044, 1'b1, 1'b0, 20'h00030, 32'h0, G,          1'b0, 1'b0, 20'h00030, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00500093, 32'h0}; tbl.push_back(v);
        v = '{1'b1, 20'h00044, 1'b1, 1'b0, 20'h00030, 32'h0, 32'h11112222, 1'b0, 1'b0, 20'h00030, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00500093, 32'h0}; tbl.push_back(v);
        v = '{1'b1, 20'h00044, 1'b1, 1'b0, 20'h00030, 32'h0, G,          1'b0, 1'b0, 20'h00030, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h11112222}; tbl.push_back(v);
        v = '{1'b1, 20'h00044, 1'b0, 1'b0, 20'h00030, 32'h0, G,          1'b1, 1'b0, 20'h00044, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00500093, 32'h11112222}; tbl.push_back(v);
        v = '{1'b1, 20'h00044, 1'b0, 1'b0, 20'h00030, 32'h0, G,          1'b0, 1'b0, 20'h00044, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00500093, 32'h11112222}; tbl.push_back(v);
        v = '{1'b1, 20'h00044, 1'b0, 1'b0, 20'h00030, 32'h0, 32'h33334444, 1'b0, 1'b0, 20'h00044, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00500093, 32'h11112222}; tbl.push_back(v);
        v = '{1'b1, 20'h00044, 1'b0, 1'b0, 20'h00030, 32'h0, G,          1'b0, 1'b0, 20'h00044, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33334444, 32'h11112222}; tbl.push_back(v);
        v = '{1'b0, 20'h00044, 1'b0, 1'b0, 20'h00030, 32'h0, G,          1'b0, 1'b0, 20'h00044, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33334444, 32'h11112222}; tbl.push_back(v);
        // Store (C0..C5); data cycle carries junk that must not be captured
        v = '{1'b0, 20'h0, 1'b0, 1'b1, 20'h00020, 32'hDEADBEEF, G,          1'b0, 1'b0, 20'h00044, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33334444, 32'h11112222}; tbl.push_back(v);
        v = '{1'b0, 20'h0, 1'b0, 1'b1, 20'h00020, 32'hDEADBEEF, G,          1'b0, 1'b1, 20'h00020, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33334444, 32'h11112222}; tbl.push_back(v);
        v = '{1'b0, 20'h0, 1'b0, 1'b1, 20'h00020, 32'hDEADBEEF, G,          1'b0, 1'b0, 20'h00020, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33334444, 32'h11112222}; tbl.push_back(v);
        v = '{1'b0, 20'h0, 1'b0, 1'b1, 20'h00020, 32'hDEADBEEF, 32'h5555AAAA, 1'b0, 1'b0, 20'h00020, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33334444, 32'h11112222}; tbl.push_back(v);
        v = '{1'b0, 20'h0, 1'b0, 1'b1, 20'h00020, 32'hDEADBEEF, G,          1'b0, 1'b0, 20'h00020, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h33334444, 32'h11112222}; tbl.push_back(v);
        v = '{1'b0, 20'h0, 1'b0, 1'b0, 20'h00020, 32'hDEADBEEF, G,          1'b0, 1'b0, 20'h00020, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h33334444, 32'h11112222}; tbl.push_back(v);

        do_reset();

        // Reset state of both instances
        @(negedge clock);
        check("reset mem_addr",  mem_addr,  32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset mem_read",  mem_read,  32'h0);
        check("reset mem_write", mem_write, 32'h0);
        check("reset i_rdata",   i_rdata,   NOP);
        check("reset d_rdata",   d_rdata,   32'h0);
        check("reset i_valid",   i_valid,   32'h0);
        check("reset d_valid",   d_valid,   32'h0);
        check("reset busy",      busy,      32'h0);
        check("reset1 i_rdata",  i_rdata1,  NOP);
        check("reset1 busy",     busy1,     32'h0);
        next_cycle();

        // Table-driven cycles
        foreach (tbl[k]) begin
            i_req = tbl[k].i_req;   i_addr = tbl[k].i_addr;
            d_read = tbl[k].d_read; d_write = tbl[k].d_write;
            d_addr = tbl[k].d_addr; d_wdata = tbl[k].d_wdata;
            mem_rdata = tbl[k].mem_rdata;
            @(negedge clock);
            check($sformatf("row%0d mem_read", k),    mem_read,    tbl[k].e_rd);
            check($sformatf("row%0d mem_write", k),   mem_write,   tbl[k].e_wr);
            check($sformatf("row%0d mem_addr", k),    mem_addr,    tbl[k].e_addr);
            check($sformatf("row%0d mem_wdata", k),   mem_wdata,   tbl[k].e_wdata);
            check($sformatf("row%0d i_valid", k),     i_valid,     tbl[k].e_iv);
            check($sformatf("row%0d d_valid", k),     d_valid,     tbl[k].e_dv);
            check($sformatf("row%0d stall_fetch", k), stall_fetch, tbl[k].e_sf);
            check($sformatf("row%0d stall_mem", k),   stall_mem,   tbl[k].e_sm);
            check($sformatf("row%0d busy", k),        busy,        tbl[k].e_busy);
            check($sformatf("row%0d i_rdata", k),     i_rdata,     tbl[k].e_ird);
            check($sformatf("row%0d d_rdata", k),     d_rdata,     tbl[k].e_drd);
            next_cycle();
        end

        // Back-to-back: both requests held, strobes must go D, I, D every 4 cycles
        i_req = 1'b1; i_addr = 20'h00200; d_read = 1'b1; d_addr = 20'h00100;
        d_write = 1'b0; d_wdata = '0; mem_rdata = 32'hCAFE0001;
        for (int c = 0; c < 14; c++) begin
            if (c == 12) begin
                i_req = 1'b0;
                d_read = 1'b0;
            end
            @(negedge clock);
            check($sformatf("b2b c%0d mem_read", c), mem_read, (c == 1 || c == 5 || c == 9));
            if (c == 1 || c == 5 || c == 9)
                check($sformatf("b2b c%0d mem_addr", c), mem_addr, (c == 5) ? 32'h200 : 32'h100);
            check($sformatf("b2b c%0d d_valid", c), d_valid, (c == 4 || c == 12));
            check($sformatf("b2b c%0d i_valid", c), i_valid, (c == 8));
            next_cycle();
        end
        check("b2b d_rdata", d_rdata, 32'hCAFE0001);
        check("b2b i_rdata", i_rdata, 32'hCAFE0001);

        // Reset one cycle after a D strobe: access aborted, no valid, registers reset
        mem_rdata = G;
        d_read = 1'b1; d_addr = 20'h00300;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) begin
                reset = 1'b1;
                d_read = 1'b0;
            end
            if (c == 3) begin
                reset = 1'b0;
                mem_rdata = 32'h77777777;
            end
            if (c == 4) mem_rdata = G;
            @(negedge clock);
            if (c == 1) check("rst strobe mem_read", mem_read, 32'h1);
            if (c == 2) check("rst c2 busy", busy, 32'h1);
            if (c >= 3) begin
                check($sformatf("rst c%0d d_valid", c), d_valid, 32'h0);
                check($sformatf("rst c%0d busy", c),    busy,    32'h0);
                check($sformatf("rst c%0d d_rdata", c), d_rdata, 32'h0);
                check($sformatf("rst c%0d i_rdata", c), i_rdata, NOP);
            end
            next_cycle();
        end

        // MEM_LATENCY=1 instance: strobe c1, data c2, i_valid c3
        i_req = 1'b1; i_addr = 20'h00ABC;
        for (int c = 0; c < 6; c++) begin
            mem_rdata1 = (c == 2) ? 32'h00A00113 : G;
            if (c == 4) i_req = 1'b0;
            @(negedge clock);
            check($sformatf("lat1 c%0d mem_read", c), mem_read1, (c == 1));
            check($sformatf("lat1 c%0d i_valid", c),  i_valid1,  (c == 3));
            check($sformatf("lat1 c%0d busy", c),     busy1,     (c == 1 || c == 2));
            if (c == 1) check("lat1 mem_addr", mem_addr1, 32'h00ABC);
            if (c >= 3) check($sformatf("lat1 c%0d i_rdata", c), i_rdata1, 32'h00A00113);
            if (c <= 2) check($sformatf("lat1 c%0d stall_fetch", c), stall_fetch1, 32'h1);
            if (c == 3) check("lat1 c3 stall_fetch", stall_fetch1, 32'h0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
